// File: rtl/uart_pkg.sv
// Shared UART definitions: rx FSM state encoding, frame geometry, default bit timing.
package uart_pkg;

   localparam int unsigned DATA_BITS            = 8;
   localparam int unsigned IDX_W                = 3;
   localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

   // Receiver FSM encoding
   localparam int unsigned      ST_W     = 3;
   localparam logic [ST_W-1:0]  S_IDLE   = 3'd0;
   localparam logic [ST_W-1:0]  S_START  = 3'd1;
   localparam logic [ST_W-1:0]  S_DATA   = 3'd2;
   localparam logic [ST_W-1:0]  S_PARITY = 3'd3;
   localparam logic [ST_W-1:0]  S_STOP   = 3'd4;
   localparam logic [ST_W-1:0]  S_BREAK  = 3'd5;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE   = S_IDLE,
      ST_START  = S_START,
      ST_DATA   = S_DATA,
      ST_PARITY = S_PARITY,
      ST_STOP   = S_STOP,
      ST_BREAK  = S_BREAK
   } rx_state_e;

   // Even parity bit for a data byte (XOR of all data bits)
   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a configurable reset value.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two back-to-back flops; the first may go metastable, the second resolves it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Asynchronous serial receiver, LSB first, 8N1 by default.
// Define UART_RX_PARITY_EN to receive 8E1 frames with a live parity_err pulse.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 busy
);

   localparam int unsigned      TMR_W    = $clog2(CLKS_PER_BIT);
   localparam int unsigned      HALF_BIT = CLKS_PER_BIT / 2;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
   localparam logic [TMR_W-1:0] TMR_MID  = TMR_W'(HALF_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   logic                 rx_s;
   logic                 rx_prev_q;
   rx_state_e            state_q,      state_d;
   logic [TMR_W-1:0]     timer_q,      timer_d;
   logic [IDX_W-1:0]     idx_q,        idx_d;
   logic [DATA_BITS-1:0] shift_q,      shift_d;
   logic [DATA_BITS-1:0] data_out_q,   data_out_d;
   logic                 data_valid_q, data_valid_d;
   logic                 frame_err_q,  frame_err_d;
   logic                 busy_q,       busy_d;
   logic                 tmr_last;
`ifdef UART_RX_PARITY_EN
   logic                 par_err_q,    par_err_d;
   logic                 parity_err_q, parity_err_d;
`endif

   // Bring the asynchronous line into the clk domain; idle-high reset value
   sync_2ff #(
      .RST_VAL (1'b1)
   ) u_rx_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (rx),
      .q_o   (rx_s)
   );

   assign tmr_last = (timer_q == TMR_LAST);

   // Next-state, datapath and output-pulse decode
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      idx_d        = idx_q;
      shift_d      = shift_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_d    = par_err_q;
      parity_err_d = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (rx_prev_q && !rx_s) begin
               state_d = ST_START;
            end
         end

         ST_START: begin
            idx_d = IDX_W'(0);
            if (timer_q == TMR_MID) begin
               state_d = rx_s ? ST_IDLE : ST_DATA;
            end
         end

         ST_DATA: begin
            if (tmr_last) begin
               shift_d[idx_q] = rx_s;
               idx_d          = idx_q + IDX_W'(1);
               if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end
         end

`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (tmr_last) begin
               par_err_d = (rx_s != even_parity(shift_q));
               state_d   = ST_STOP;
            end
         end
`endif

         ST_STOP: begin
            if (tmr_last) begin
               if (!rx_s) begin
                  // Framing error outranks parity error
                  frame_err_d = 1'b1;
                  state_d     = ST_BREAK;
`ifdef UART_RX_PARITY_EN
               end else if (par_err_q) begin
                  parity_err_d = 1'b1;
                  state_d      = ST_IDLE;
`endif
               end else begin
                  data_valid_d = 1'b1;
                  data_out_d   = shift_q;
                  state_d      = ST_IDLE;
               end
            end
         end

         ST_BREAK: begin
            if (rx_s) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Bit timer restarts on every state entry and at each bit boundary
      if ((state_d != state_q) || tmr_last) begin
         timer_d = TMR_W'(0);
      end else if (state_q != ST_IDLE && state_q != ST_BREAK) begin
         timer_d = timer_q + TMR_W'(1);
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rx_prev_q    <= 1'b1;
         timer_q      <= TMR_W'(0);
         idx_q        <= IDX_W'(0);
         shift_q      <= DATA_BITS'(0);
         data_out_q   <= DATA_BITS'(0);
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rx_prev_q    <= rx_s;
         timer_q      <= timer_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         frame_err_q  <= frame_err_d;
         busy_q       <= busy_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity check result held across the stop bit, plus its output pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_err_q    <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         par_err_q    <= par_err_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign frame_err  = frame_err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clks/bit with a frame-level expected-event model.
module tb_uart_rx;

   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN  = 1'b1;
   localparam int NB      = 10;
   localparam int LAT_LIT = 171;
`else
   localparam bit PAR_EN  = 1'b0;
   localparam int NB      = 9;
   localparam int LAT_LIT = 155;
`endif

   localparam logic [2:0] K_VALID = 3'b001;
   localparam logic [2:0] K_PAR   = 3'b010;
   localparam logic [2:0] K_FRM   = 3'b100;

   typedef struct {
      logic [2:0] kind;
      logic [7:0] data;
      int         cyc;
   } ev_t;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx    = 1'b1;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       parity_err;
   logic       busy;

   int         cyc         = 0;
   int         vectors     = 0;
   int         miscompares = 0;
   int         last_ev_cyc = 0;
   logic [7:0] last_good   = 8'h00;
   ev_t        exp_q[$];

   uart_rx #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .data_out   (data_out),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Queue the outcome a frame must produce, then shift it onto the line
   task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_bit);
      ev_t ev;
      ev.data = d;
      // 2 sync flops + edge detect + half-bit start check + full data/parity/stop bits
      ev.cyc  = cyc + 3 + HALF + NB * CPB;
      if (!stop_bit)                ev.kind = K_FRM;
      else if (PAR_EN && par_flip)  ev.kind = K_PAR;
      else                          ev.kind = K_VALID;
      exp_q.push_back(ev);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (PAR_EN) drive_bit((^d) ^ par_flip);
      drive_bit(stop_bit);
   endtask

   // Per-cycle comparison of DUT outputs against the frame model
   always begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
         last_good = 8'h00;
         check("rst_data_out",   32'(data_out),   32'h0);
         check("rst_data_valid", 32'(data_valid), 32'h0);
         check("rst_frame_err",  32'(frame_err),  32'h0);
         check("rst_parity_err", 32'(parity_err), 32'h0);
         check("rst_busy",       32'(busy),       32'h0);
      end else begin
         check("pulse_excl",
               32'((32'(data_valid) + 32'(frame_err) + 32'(parity_err)) <= 1), 32'h1);
         if (data_valid || frame_err || parity_err) begin
            if (exp_q.size() == 0) begin
               check("unexpected_pulse", 32'({frame_err, parity_err, data_valid}), 32'h0);
            end else begin
               ev_t ev;
               ev = exp_q.pop_front();
               check("pulse_kind",  32'({frame_err, parity_err, data_valid}), 32'(ev.kind));
               check("pulse_cycle", 32'(cyc), 32'(ev.cyc));
               check("busy_at_pulse", 32'(busy), (ev.kind == K_FRM) ? 32'h1 : 32'h0);
               if (ev.kind == K_VALID) last_good = ev.data;
               last_ev_cyc = cyc;
            end
         end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            check("missed_pulse", 32'(cyc), 32'(exp_q[0].cyc));
            void'(exp_q.pop_front());
         end
         check("data_out", 32'(data_out), 32'(last_good));
      end
   end

   initial begin
      int c0;
      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Plain frame: single pulse, fixed latency
      c0 = cyc;
      send_frame(8'h55, 1'b0, 1'b1);
      idle(CPB);
      check("lat_first", 32'(last_ev_cyc - c0), 32'(LAT_LIT));
      check("lit_55", 32'(data_out), 32'h55);
      check("busy_idle_55", 32'(busy), 32'h0);

      // Short low glitch is rejected at the start-bit midpoint
      c0 = cyc;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      check("glitch_busy_set", 32'(busy), 32'h1);
      repeat (7) @(negedge clk);
      check("glitch_busy_clear", 32'(busy), 32'h0);
      check("glitch_cycles", 32'(cyc - c0), 32'd11);
      idle(CPB);
      send_frame(8'hC3, 1'b0, 1'b1);
      idle(CPB);
      check("lit_c3", 32'(data_out), 32'hC3);

      // Stop bit low: frame error, line held low keeps the receiver parked
      send_frame(8'hA3, 1'b0, 1'b0);
      repeat (2 * CPB) @(negedge clk);
      check("break_busy", 32'(busy), 32'h1);
      check("lit_keep_c3", 32'(data_out), 32'hC3);
      rx = 1'b1;
      repeat (8) @(negedge clk);
      check("break_exit_busy", 32'(busy), 32'h0);
      idle(CPB);
      send_frame(8'h3C, 1'b0, 1'b1);
      idle(CPB);
      check("lit_3c", 32'(data_out), 32'h3C);

      // Back-to-back frames with no idle gap
      send_frame(8'h00, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b1);
      idle(CPB);
      check("lit_ff", 32'(data_out), 32'hFF);

      // Reset in the middle of data bit 4 discards the partial byte
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(i[0]);
      rx = 1'b0;
      repeat (HALF) @(negedge clk);
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      check("lit_rst_data", 32'(data_out), 32'h0);
      rx    = 1'b1;
      rst_n = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      check("lit_post_rst", 32'(data_out), 32'h0);
      check("post_rst_busy", 32'(busy), 32'h0);
      send_frame(8'h81, 1'b0, 1'b1);
      idle(CPB);
      check("lit_81", 32'(data_out), 32'h81);

`ifdef UART_RX_PARITY_EN
      // 0x07 has three ones: even parity bit must be 1
      send_frame(8'h07, 1'b1, 1'b1);
      idle(CPB);
      check("lit_par_keep_81", 32'(data_out), 32'h81);
      send_frame(8'h07, 1'b0, 1'b1);
      idle(CPB);
      check("lit_07", 32'(data_out), 32'h07);
`endif

      idle(2 * CPB);
      check("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
